// File: rtl/dcache_bypass_pkg.sv
// Shared definitions for the uncached dcache stand-in: request op encoding and FSM state type.
package dcache_bypass_pkg;

  typedef enum logic {
    DC_OP_READ  = 1'b0,
    DC_OP_WRITE = 1'b1
  } dc_op_e;

  typedef enum logic [2:0] {
    BP_IDLE,
    BP_P0_REQ,
    BP_P0_WAIT,
    BP_P1_REQ,
    BP_P1_WAIT,
    BP_RESP
  } bp_state_e;

endpackage

// File: rtl/dcache_bypass.sv
// Storage-less dcache responder: each accepted port access becomes one single-beat memory transaction,
// with a p0+p1 pair serialized p0 then p1 and completed by a single data_ok pulse.
module dcache_bypass
  import dcache_bypass_pkg::*;
#(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p0_valid,
  input  logic                p1_valid,
  input  logic [2:0]          op,
  input  logic [TAG_W-1:0]    tag,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] p0_offset,
  input  logic [OFFSET_W-1:0] p1_offset,
  input  logic [3:0]          p0_wstrb,
  input  logic [3:0]          p1_wstrb,
  input  logic [31:0]         p0_wdata,
  input  logic [31:0]         p1_wdata,
  input  logic                uncached,
  input  logic [1:0]          p0_size,
  input  logic [1:0]          p1_size,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [31:0]         p0_rdata,
  output logic [31:0]         p1_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [1:0]          mem_size,
  output logic [3:0]          mem_wstrb,
  output logic [31:0]         mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [31:0]         mem_rdata
);

  if (TAG_W + INDEX_W + OFFSET_W != 32) begin : g_width_chk
    $error("dcache_bypass: TAG_W+INDEX_W+OFFSET_W must equal 32");
  end

  bp_state_e           state, state_nxt;
  dc_op_e              op_q;
  logic                pair_q;
  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  index_q;
  logic [OFFSET_W-1:0] off0_q, off1_q;
  logic [3:0]          strb0_q, strb1_q;
  logic [31:0]         wdata0_q, wdata1_q;
  logic [1:0]          size0_q, size1_q;
  logic                accept;
  logic                sel_p1;

  // Every access bypasses, so the uncached hint and the upper op bits carry no information here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, uncached, op[2:1]};

  assign addr_ok = (state == BP_IDLE) && !reset;
  assign accept  = addr_ok && p0_valid;
  assign data_ok = (state == BP_RESP);
  assign sel_p1  = (state == BP_P1_REQ) || (state == BP_P1_WAIT);

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    case (state)
      BP_IDLE:    if (p0_valid) state_nxt = BP_P0_REQ;
      BP_P0_REQ: begin
        mem_req = 1'b1;
        if (mem_addr_ok) state_nxt = BP_P0_WAIT;
      end
      BP_P0_WAIT: if (mem_data_ok) state_nxt = pair_q ? BP_P1_REQ : BP_RESP;
      BP_P1_REQ: begin
        mem_req = 1'b1;
        if (mem_addr_ok) state_nxt = BP_P1_WAIT;
      end
      BP_P1_WAIT: if (mem_data_ok) state_nxt = BP_RESP;
      BP_RESP:    state_nxt = BP_IDLE;
      default:    state_nxt = BP_IDLE;
    endcase
  end

  // Memory beat attributes come only from the latched request, never from the live inputs.
  assign mem_we    = mem_req && (op_q == DC_OP_WRITE);
  assign mem_addr  = {tag_q, index_q, sel_p1 ? off1_q : off0_q};
  assign mem_size  = sel_p1 ? size1_q  : size0_q;
  assign mem_wstrb = sel_p1 ? strb1_q  : strb0_q;
  assign mem_wdata = sel_p1 ? wdata1_q : wdata0_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BP_IDLE;
      op_q     <= DC_OP_READ;
      pair_q   <= 1'b0;
      tag_q    <= '0;
      index_q  <= '0;
      off0_q   <= '0;
      off1_q   <= '0;
      strb0_q  <= '0;
      strb1_q  <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
      size0_q  <= '0;
      size1_q  <= '0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q     <= dc_op_e'(op[0]);
        pair_q   <= p1_valid;
        tag_q    <= tag;
        index_q  <= index;
        off0_q   <= p0_offset;
        off1_q   <= p1_offset;
        strb0_q  <= p0_wstrb;
        strb1_q  <= p1_wstrb;
        wdata0_q <= p0_wdata;
        wdata1_q <= p1_wdata;
        size0_q  <= p0_size;
        size1_q  <= p1_size;
      end
      // Write acks leave the read-data registers untouched.
      if (state == BP_P0_WAIT && mem_data_ok && op_q == DC_OP_READ) p0_rdata <= mem_rdata;
      if (state == BP_P1_WAIT && mem_data_ok && op_q == DC_OP_READ) p1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dcache_bypass.sv
// Scoreboard bench for dcache_bypass: directed requests against a small SRAM-like memory responder.
module tb_dcache_bypass;

  logic        clk, reset;
  logic        p0_valid, p1_valid;
  logic [2:0]  op;
  logic [19:0] tag;
  logic [6:0]  index;
  logic [4:0]  p0_offset, p1_offset;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic [31:0] p0_wdata, p1_wdata;
  logic        uncached;
  logic [1:0]  p0_size, p1_size;
  logic        addr_ok, data_ok;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  dcache_bypass #(.TAG_W(20), .INDEX_W(7), .OFFSET_W(5)) dut (
    .clk(clk), .reset(reset), .p0_valid(p0_valid), .p1_valid(p1_valid), .op(op),
    .tag(tag), .index(index), .p0_offset(p0_offset), .p1_offset(p1_offset),
    .p0_wstrb(p0_wstrb), .p1_wstrb(p1_wstrb), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .uncached(uncached), .p0_size(p0_size), .p1_size(p1_size),
    .addr_ok(addr_ok), .data_ok(data_ok), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [1:0]  size;
  } beat_t;

  typedef struct packed {
    logic [31:0] r0;
    logic [31:0] r1;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    acc_wait = 0;
  int    stall = 0;
  int    resp_delay = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h1c000010) return 32'hdeadbeef;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check_beat();
    beat_t e;
    if (beat_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_beat: actual addr %h expected no beat", mem_addr);
    end else begin
      e = beat_q.pop_front();
      chk("beat_addr", mem_addr, e.addr);
      chk("beat_we", {31'b0, mem_we}, {31'b0, e.we});
      chk("beat_strb", {28'b0, mem_wstrb}, {28'b0, e.strb});
      chk("beat_wdata", mem_wdata, e.wdata);
      chk("beat_size", {30'b0, mem_size}, {30'b0, e.size});
    end
  endtask

  // Memory responder: optional addr_ok stall, then data_ok resp_delay cycles after the handshake.
  initial begin : mem_model
    bit          hs;
    int          pend;
    logic [31:0] pend_data;
    hs = 1'b0;
    pend = 0;
    pend_data = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_data_ok = 1'b0;
      if (hs) begin
        hs = 1'b0;
        pend = resp_delay + 1;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_data_ok = 1'b1;
          mem_rdata = pend_data;
        end
      end
      if (mem_req && stall == 0) begin
        mem_addr_ok = 1'b1;
        hs = 1'b1;
        pend_data = mem_val(mem_addr);
        check_beat();
      end else begin
        mem_addr_ok = 1'b0;
        if (mem_req) stall--;
      end
    end
  end

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (data_ok) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_ok: actual 1 expected 0 at cycle %0d", cyc);
      end else begin
        e = rsp_q.pop_front();
        chk("p0_rdata", p0_rdata, e.r0);
        chk("p1_rdata", p1_rdata, e.r1);
      end
    end
  end

  task automatic issue(input logic p1v, input logic wr, input logic [19:0] tg, input logic [6:0] ix,
                       input logic [4:0] o0, input logic [4:0] o1, input logic [3:0] s0,
                       input logic [3:0] s1, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [1:0] z0, input logic [1:0] z1);
    bit ok;
    @(posedge clk);
    #1;
    p0_valid = 1'b1;
    p1_valid = p1v;
    op = {2'b10, wr};
    tag = tg;
    index = ix;
    p0_offset = o0;
    p1_offset = o1;
    p0_wstrb = s0;
    p1_wstrb = s1;
    p0_wdata = w0;
    p1_wdata = w1;
    p0_size = z0;
    p1_size = z1;
    ok = 1'b0;
    acc_wait = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (addr_ok) begin
        ok = 1'b1;
        break;
      end
      acc_wait++;
    end
    acc_cyc = cyc;
    chk("accept", {31'b0, ok}, 32'd1);
    @(posedge clk);
    #1;
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    op = 3'($urandom);
    tag = 20'($urandom);
    index = 7'($urandom);
    p0_offset = 5'($urandom);
    p1_offset = 5'($urandom);
    p0_wstrb = 4'($urandom);
    p1_wstrb = 4'($urandom);
    p0_wdata = $urandom;
    p1_wdata = $urandom;
    p0_size = 2'($urandom);
    p1_size = 2'($urandom);
  endtask

  task automatic wait_done(input int lat);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (data_ok) begin
        got = 1'b1;
        break;
      end
    end
    chk("data_ok_seen", {31'b0, got}, 32'd1);
    if (got) chk("latency", 32'(cyc - acc_cyc), 32'(lat));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    reset = 1'b1;
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    op = '0;
    tag = '0;
    index = '0;
    p0_offset = '0;
    p1_offset = '0;
    p0_wstrb = '0;
    p1_wstrb = '0;
    p0_wdata = '0;
    p1_wdata = '0;
    uncached = 1'b1;
    p0_size = '0;
    p1_size = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_ok", {31'b0, addr_ok}, 32'd0);
    chk("rst_data_ok", {31'b0, data_ok}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_p1_rdata", p1_rdata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_addr_ok", {31'b0, addr_ok}, 32'd1);

    // single read
    rsp_q.push_back('{32'hdeadbeef, 32'h0});
    beat_q.push_back('{32'h1c000010, 1'b0, 4'hf, 32'h0, 2'd2});
    issue(1'b0, 1'b0, 20'h1c000, 7'h0, 5'h10, 5'h00, 4'hf, 4'hf, 32'h0, 32'h0, 2'd2, 2'd2);
    wait_done(3);

    // pair read
    rsp_q.push_back('{32'hdeadbeef, 32'h0014ffeb});
    beat_q.push_back('{32'h1c000010, 1'b0, 4'hf, 32'h0, 2'd2});
    beat_q.push_back('{32'h1c000014, 1'b0, 4'hf, 32'h0, 2'd2});
    issue(1'b1, 1'b0, 20'h1c000, 7'h0, 5'h10, 5'h14, 4'hf, 4'hf, 32'h0, 32'h0, 2'd2, 2'd2);
    wait_done(5);

    // pair write leaves rdata unchanged
    rsp_q.push_back('{32'hdeadbeef, 32'h0014ffeb});
    beat_q.push_back('{32'h1c000008, 1'b1, 4'b0011, 32'h11112222, 2'd1});
    beat_q.push_back('{32'h1c00000c, 1'b1, 4'b1100, 32'h33334444, 2'd1});
    issue(1'b1, 1'b1, 20'h1c000, 7'h0, 5'h08, 5'h0c, 4'b0011, 4'b1100,
          32'h11112222, 32'h33334444, 2'd1, 2'd1);
    wait_done(5);

    // addr_ok backpressure for 5 cycles
    stall = 5;
    rsp_q.push_back('{32'h5544aabb, 32'h0014ffeb});
    beat_q.push_back('{32'h12345544, 1'b0, 4'hf, 32'h0, 2'd2});
    issue(1'b0, 1'b0, 20'h12345, 7'h2a, 5'h04, 5'h00, 4'hf, 4'hf, 32'h0, 32'h0, 2'd2, 2'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_mem_req", {31'b0, mem_req}, 32'd1);
      chk("bp_addr_ok", {31'b0, addr_ok}, 32'd0);
      chk("bp_mem_addr", mem_addr, 32'h12345544);
    end
    wait_done(8);

    // p1_valid alone is not accepted
    @(posedge clk);
    #1;
    p1_valid = 1'b1;
    p0_valid = 1'b0;
    tag = 20'h1c000;
    index = 7'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("p1only_mem_req", {31'b0, mem_req}, 32'd0);
      chk("p1only_addr_ok", {31'b0, addr_ok}, 32'd1);
    end
    rsp_q.push_back('{32'h0018ffe7, 32'h001cffe3});
    beat_q.push_back('{32'h1c000018, 1'b0, 4'hf, 32'h0, 2'd2});
    beat_q.push_back('{32'h1c00001c, 1'b0, 4'hf, 32'h0, 2'd2});
    issue(1'b1, 1'b0, 20'h1c000, 7'h0, 5'h18, 5'h1c, 4'hf, 4'hf, 32'h0, 32'h0, 2'd2, 2'd2);
    chk("accept_same_cycle", 32'(acc_wait), 32'd0);
    wait_done(5);

    // reset while waiting for the read beat; the late mem_data_ok must be ignored
    resp_delay = 3;
    beat_q.push_back('{32'h1c000010, 1'b0, 4'hf, 32'h0, 2'd2});
    issue(1'b0, 1'b0, 20'h1c000, 7'h0, 5'h10, 5'h00, 4'hf, 4'hf, 32'h0, 32'h0, 2'd2, 2'd2);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      n++;
    end
    chk("rst_mid_in_wait", {31'b0, mem_req}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_addr_ok_low", {31'b0, addr_ok}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_addr_ok", {31'b0, addr_ok}, 32'd1);
    chk("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (data_ok) n++;
    end
    chk("rst_mid_no_data_ok", 32'(n), 32'd0);
    chk("rst_mid_idle", {31'b0, addr_ok}, 32'd1);
    chk("rst_mid_p0_rdata", p0_rdata, 32'h0);
    chk("rst_mid_p1_rdata", p1_rdata, 32'h0);
    resp_delay = 0;

    // recovery read after reset
    rsp_q.push_back('{32'hdeadbeef, 32'h0});
    beat_q.push_back('{32'h1c000010, 1'b0, 4'hf, 32'h0, 2'd2});
    issue(1'b0, 1'b0, 20'h1c000, 7'h0, 5'h10, 5'h00, 4'hf, 4'hf, 32'h0, 32'h0, 2'd2, 2'd2);
    wait_done(3);

    repeat (4) @(posedge clk);
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    chk("beat_queue_empty", 32'(beat_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
